// File: rtl/ram_dump_ctrl.sv
// Read-only RAM sweeper: on CPU halt or a start pulse it takes the RAM override port,
// reads every word in ascending order and streams kept (address, data) records.
module ram_dump_ctrl #(
    parameter int unsigned WORDS     = 4096,
    parameter bit          SKIP_ZERO = 1'b1,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        halt,
    input  logic        start,
    output logic        tbCTRL,
    output logic        WEN,
    output logic        REN,
    output logic [31:0] addr,
    output logic [31:0] store,
    input  logic [31:0] load,
    input  logic [1:0]  ramstate,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_addr,
    output logic [31:0] out_data,
    output logic        done,
    output logic        error
);

    localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        READ,
        EMIT,
        NEXT,
        DONE,
        FAIL
    } state_t;

    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ram_t;

    state_t        state;
    state_t        next_state;
    logic [IW-1:0] index;
    logic [TW-1:0] timer;
    logic          halt_q;
    logic [31:0]   out_addr_r;
    logic [31:0]   out_data_r;

    logic          trigger;
    logic          capture;
    logic          index_inc;
    logic          index_clr;
    logic          timer_inc;
    logic          timer_clr;

    assign trigger = (halt && !halt_q) || start;

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        index_inc  = 1'b0;
        index_clr  = 1'b0;
        timer_inc  = 1'b0;
        timer_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    next_state = ARB;
                    index_clr  = 1'b1;
                end
            end
            ARB: begin
                next_state = READ;
                timer_clr  = 1'b1;
            end
            READ: begin
                if (ramstate == RAM_ACCESS) begin
                    capture    = 1'b1;
                    next_state = (SKIP_ZERO && (load == '0)) ? NEXT : EMIT;
                end else if (ramstate == RAM_ERROR) begin
                    next_state = FAIL;
                end else if (timer == TW'(TIMEOUT)) begin
                    next_state = FAIL;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            EMIT: begin
                if (out_ready) next_state = NEXT;
            end
            NEXT: begin
                // Ownership is already held, so the next word goes straight to READ.
                if (index == IW'(WORDS - 1)) begin
                    next_state = DONE;
                end else begin
                    next_state = READ;
                    index_inc  = 1'b1;
                    timer_clr  = 1'b1;
                end
            end
            DONE:    next_state = DONE;
            FAIL:    next_state = FAIL;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            index      <= '0;
            timer      <= '0;
            halt_q     <= 1'b0;
            out_addr_r <= '0;
            out_data_r <= '0;
        end else begin
            state  <= next_state;
            halt_q <= halt;
            if (index_clr) begin
                index <= '0;
            end else if (index_inc) begin
                index <= index + 1'b1;
            end
            if (timer_clr) begin
                timer <= '0;
            end else if (timer_inc) begin
                timer <= timer + 1'b1;
            end
            if (capture) begin
                out_addr_r <= addr;
                out_data_r <= load;
            end
        end
    end

    assign tbCTRL    = (state != IDLE);
    assign REN       = (state == READ);
    assign out_valid = (state == EMIT);
    assign done      = (state == DONE);
    assign error     = (state == FAIL);
    assign WEN       = 1'b0;
    assign store     = '0;
    assign addr      = tbCTRL ? (32'(index) << 2) : '0;
    assign out_addr  = out_addr_r;
    assign out_data  = out_data_r;

endmodule
